// File: rtl/jump_pc_pkg.sv
// Shared types and constants for the jump PC sequencer: FSM states,
// next-PC select codes and the sequential PC increment.
package jump_pc_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_TRAP = 3'd4
  } next_sel_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/jump_pc_sequencer_target_calc.sv
// Combinational next-PC target generation: jump/branch targets, the
// misaligned-JR flag and the priority-resolved select code.
module pc_target_calc
  import jump_pc_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [27:0] jump_addr_i,
  input  logic [31:0] branch_off_i,
  input  logic [31:0] jr_addr_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic        branch_taken_i,
  output next_sel_e   sel_o,
  output logic [31:0] jump_target_o,
  output logic [31:0] branch_target_o,
  output logic        misaligned_o
);

  assign jump_target_o   = {pc_plus4_i[31:28], jump_addr_i};
  assign branch_target_o = pc_plus4_i + branch_off_i;
  assign misaligned_o    = jr_i && (jr_addr_i[1:0] != 2'b00);

  // Priority: jr > jump > branch > sequential
  always_comb begin
    sel_o = SEL_SEQ;
    if (jr_i) begin
      sel_o = misaligned_o ? SEL_TRAP : SEL_JR;
    end else if (jump_i) begin
      sel_o = SEL_J;
    end else if (branch_taken_i) begin
      sel_o = SEL_BR;
    end
  end

endmodule

// File: rtl/jump_pc_sequencer.sv
// Architectural PC register with post-reset settling window, fetch
// handshake, stall hold and a one-cycle trap on misaligned JR targets.
module jump_pc_sequencer
  import jump_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC     = 32'h0000_0080,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [27:0] jump_addr_i,
  input  logic [31:0] branch_off_i,
  input  logic [31:0] jr_addr_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic        branch_taken_i,
  input  logic        stall_i,
  input  logic        fetch_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        pc_valid_o,
  output logic        redirect_o,
  output logic        trap_o
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        trap_q, trap_d;

  next_sel_e   sel;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        misaligned;
  logic        advance;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + PC_STEP;
  assign pc_valid_o = (state_q == ST_RUN);
  assign redirect_o = redirect_q;
  assign trap_o     = trap_q;
  assign advance    = pc_valid_o && fetch_ready_i && !stall_i;

  pc_target_calc u_target_calc (
    .pc_plus4_i      (pc_plus4_o),
    .jump_addr_i     (jump_addr_i),
    .branch_off_i    (branch_off_i),
    .jr_addr_i       (jr_addr_i),
    .jump_i          (jump_i),
    .jr_i            (jr_i),
    .branch_taken_i  (branch_taken_i),
    .sel_o           (sel),
    .jump_target_o   (jump_target),
    .branch_target_o (branch_target),
    .misaligned_o    (misaligned)
  );

  // Control inputs are only looked at on an advance, so X on them while
  // the PC is not valid cannot leak into state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    trap_d     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (advance) begin
          redirect_d = (sel != SEL_SEQ);
          unique case (sel)
            SEL_JR:   pc_d = jr_addr_i;
            SEL_J:    pc_d = jump_target;
            SEL_BR:   pc_d = branch_target;
            SEL_TRAP: begin
              pc_d    = TRAP_PC;
              trap_d  = 1'b1;
              state_d = ST_TRAP;
            end
            default:  pc_d = pc_plus4_o;
          endcase
        end
      end
      ST_TRAP: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_INIT;
      cnt_q      <= 4'd0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      trap_q     <= trap_d;
    end
  end

  // Unused in this configuration path but kept visible for debug probes
  logic unused_misaligned;
  assign unused_misaligned = misaligned;

endmodule

// File: tb/tb_jump_pc_sequencer.sv
// Directed self-checking bench for jump_pc_sequencer with default parameters.
module tb_jump_pc_sequencer;

  logic        clk_i;
  logic        rst_i;
  logic [27:0] jump_addr_i;
  logic [31:0] branch_off_i;
  logic [31:0] jr_addr_i;
  logic        jump_i;
  logic        jr_i;
  logic        branch_taken_i;
  logic        stall_i;
  logic        fetch_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pc_valid_o;
  logic        redirect_o;
  logic        trap_o;

  int checks = 0;
  int errors = 0;

  jump_pc_sequencer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .jump_addr_i    (jump_addr_i),
    .branch_off_i   (branch_off_i),
    .jr_addr_i      (jr_addr_i),
    .jump_i         (jump_i),
    .jr_i           (jr_i),
    .branch_taken_i (branch_taken_i),
    .stall_i        (stall_i),
    .fetch_ready_i  (fetch_ready_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .pc_valid_o     (pc_valid_o),
    .redirect_o     (redirect_o),
    .trap_o         (trap_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic jr, input logic jmp, input logic br,
                               input logic stall, input logic ready,
                               input logic [27:0] jaddr, input logic [31:0] boff,
                               input logic [31:0] jraddr);
    jr_i           = jr;
    jump_i         = jmp;
    branch_taken_i = br;
    stall_i        = stall;
    fetch_ready_i  = ready;
    jump_addr_i    = jaddr;
    branch_off_i   = boff;
    jr_addr_i      = jraddr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'h0);
    #12;
    checkOutput("rst_pc", pc_o, 32'h0000_0000);
    checkOutput("rst_pc4", pc_plus4_o, 32'h0000_0004);
    checkBit("rst_valid", pc_valid_o, 1'b0);
    checkBit("rst_redirect", redirect_o, 1'b0);
    checkBit("rst_trap", trap_o, 1'b0);

    rst_i = 1'b1;
    step();
    checkBit("init_valid1", pc_valid_o, 1'b0);
    step();
    checkBit("init_valid2", pc_valid_o, 1'b1);
    checkOutput("run_pc0", pc_o, 32'h0000_0000);
    step();
    checkOutput("seq_pc4", pc_o, 32'h0000_0004);
    checkBit("seq_noredir", redirect_o, 1'b0);
    step();
    checkOutput("seq_pc8", pc_o, 32'h0000_0008);
    step();
    checkOutput("seq_pc12", pc_o, 32'h0000_000C);

    // Jump into the 0x1000_0000 region
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'h1000_0008);
    step();
    checkOutput("jr_setup", pc_o, 32'h1000_0008);
    checkBit("jr_redirect", redirect_o, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'h0000_040, 32'h0, 32'h0);
    step();
    checkOutput("jump_pc", pc_o, 32'h1000_0040);
    checkBit("jump_redirect", redirect_o, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0, 32'h0, 32'h0);
    step();
    checkOutput("idle_hold", pc_o, 32'h1000_0040);
    checkBit("redirect_pulse_end", redirect_o, 1'b0);

    // Jump beats branch, then branch alone
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'h0000_0100);
    step();
    checkOutput("jr_0x100", pc_o, 32'h0000_0100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 28'h0000_200, 32'hFFFF_FFF0, 32'h0);
    step();
    checkOutput("jump_over_branch", pc_o, 32'h0000_0200);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'h0000_0100);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 28'h0000_200, 32'hFFFF_FFF0, 32'h0);
    step();
    checkOutput("branch_back", pc_o, 32'h0000_00F4);
    checkBit("branch_redirect", redirect_o, 1'b1);

    // Misaligned JR traps; the TRAP-cycle inputs must be ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'h0000_2002);
    step();
    checkOutput("trap_pc", pc_o, 32'h0000_0080);
    checkBit("trap_pulse", trap_o, 1'b1);
    checkBit("trap_valid", pc_valid_o, 1'b0);
    checkBit("trap_redirect", redirect_o, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'h0000_3000);
    step();
    checkOutput("post_trap_pc", pc_o, 32'h0000_0080);
    checkBit("post_trap_trap", trap_o, 1'b0);
    checkBit("post_trap_valid", pc_valid_o, 1'b1);
    checkBit("post_trap_redirect", redirect_o, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'h0000_2000);
    step();
    checkOutput("jr_aligned", pc_o, 32'h0000_2000);
    checkBit("jr_aligned_trap", trap_o, 1'b0);

    // Stall and not-ready both hold the PC
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 28'h123_4560, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_hold", pc_o, 32'h0000_2000);
      checkBit("stall_noredir", redirect_o, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h123_4560, 32'h0, 32'h0);
    step();
    checkOutput("notready_hold", pc_o, 32'h0000_2000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'h123_4560, 32'h0, 32'h0);
    step();
    checkOutput("jump_after_stall", pc_o, 32'h0123_4560);
    checkBit("jump_after_stall_redir", redirect_o, 1'b1);

    // Wrap at the top of the address space
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'hFFFF_FFFC);
    step();
    checkOutput("wrap_setup", pc_o, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", pc_plus4_o, 32'h0000_0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'h0);
    step();
    checkOutput("wrap_seq", pc_o, 32'h0000_0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 32'h0, 32'hFFFF_FFFC);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'h000_0010, 32'h0, 32'h0);
    step();
    checkOutput("wrap_jump_region", pc_o, 32'h0000_0010);

    // Asynchronous reset mid-cycle, then settling with stall and JR pending
    #3;
    rst_i = 1'b0;
    #1;
    checkOutput("async_rst_pc", pc_o, 32'h0000_0000);
    checkBit("async_rst_valid", pc_valid_o, 1'b0);
    checkBit("async_rst_redirect", redirect_o, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 28'h0, 32'h0, 32'h0000_0003);
    #2;
    rst_i = 1'b1;
    step();
    checkBit("reinit_valid1", pc_valid_o, 1'b0);
    step();
    checkBit("reinit_valid2", pc_valid_o, 1'b1);
    checkOutput("reinit_pc", pc_o, 32'h0000_0000);
    step();
    checkOutput("reinit_stall_hold", pc_o, 32'h0000_0000);
    checkBit("reinit_no_trap", trap_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
